// File: rtl/tl_traffic_model.sv
// Intersection plant model: turns light codes and car arrivals into per-street queues,
// departure pulses and the Ta/Tb sensors fed back to the traffic-light controller.

module tl_street #(
   parameter int QDEPTH      = 7,
   parameter int QW          = 4,
   parameter int PASS_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [1:0]    light,
   input  logic          arr,
   output logic [QW-1:0] cnt,
   output logic          pass,
   output logic          ovf
);

   localparam int TW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
   localparam logic [TW-1:0] TLAST = TW'(PASS_CYCLES - 1);
   localparam logic [QW-1:0] QFULL = QW'(QDEPTH);

   typedef enum logic {IDLE, CROSS} cross_state_t;

   cross_state_t  state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic [QW-1:0] cnt_next;
   logic          green, depart, ovf_set;

   assign green = (light == 2'b00);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
         cnt   <= '0;
         pass  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         timer <= timer_next;
         cnt   <= cnt_next;
         pass  <= depart;
         if (ovf_set)
            ovf <= 1'b1;
      end
   end

   // Any non-green light while crossing abandons the car; it stays queued and must restart.
   always_comb begin
      state_next = state;
      timer_next = timer;
      depart     = 1'b0;
      case (state)
         IDLE: begin
            if (green && (cnt != '0)) begin
               state_next = CROSS;
               timer_next = '0;
            end
         end
         CROSS: begin
            if (!green) begin
               state_next = IDLE;
               timer_next = '0;
            end else if (timer == TLAST) begin
               depart     = 1'b1;
               state_next = IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   // Arrival and departure together cancel out, so a full queue does not overflow then.
   always_comb begin
      cnt_next = cnt;
      ovf_set  = 1'b0;
      if (arr && !depart) begin
         if (cnt < QFULL)
            cnt_next = cnt + 1'b1;
         else
            ovf_set = 1'b1;
      end else if (!arr && depart) begin
         cnt_next = cnt - 1'b1;
      end
   end

endmodule

module tl_traffic_model #(
   parameter int QDEPTH      = 7,
   parameter int QW          = 4,
   parameter int PASS_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [1:0]    La,
   input  logic [1:0]    Lb,
   input  logic          arr_a,
   input  logic          arr_b,
   output logic          Ta,
   output logic          Tb,
   output logic [QW-1:0] cnt_a,
   output logic [QW-1:0] cnt_b,
   output logic          pass_a,
   output logic          pass_b,
   output logic          ovf_a,
   output logic          ovf_b,
   output logic          conflict
);

   localparam logic [1:0] RED     = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   logic unsafe;

   tl_street #(.QDEPTH(QDEPTH), .QW(QW), .PASS_CYCLES(PASS_CYCLES)) street_a (
      .clk     (clk),
      .reset_n (reset_n),
      .light   (La),
      .arr     (arr_a),
      .cnt     (cnt_a),
      .pass    (pass_a),
      .ovf     (ovf_a)
   );

   tl_street #(.QDEPTH(QDEPTH), .QW(QW), .PASS_CYCLES(PASS_CYCLES)) street_b (
      .clk     (clk),
      .reset_n (reset_n),
      .light   (Lb),
      .arr     (arr_b),
      .cnt     (cnt_b),
      .pass    (pass_b),
      .ovf     (ovf_b)
   );

   assign Ta = (cnt_a != '0);
   assign Tb = (cnt_b != '0);

   assign unsafe = ((La != RED) && (Lb != RED)) || (La == ILLEGAL) || (Lb == ILLEGAL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         conflict <= 1'b0;
      else if (unsafe)
         conflict <= 1'b1;
   end

endmodule

// File: tb/tb_tl_traffic_model.sv
// Self-checking bench for tl_traffic_model: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue/age model of both streets.

module tb_tl_traffic_model;

   localparam int QDEPTH      = 7;
   localparam int QW          = 4;
   localparam int PASS_CYCLES = 2;

   localparam logic [1:0] GREEN   = 2'b00;
   localparam logic [1:0] YELLOW  = 2'b01;
   localparam logic [1:0] RED     = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    La, Lb;
   logic          arr_a, arr_b;
   logic          Ta, Tb;
   logic [QW-1:0] cnt_a, cnt_b;
   logic          pass_a, pass_b, ovf_a, ovf_b, conflict;

   int tests = 0;
   int fails = 0;

   int m_cnt  [2];
   int m_age  [2];
   bit m_pass [2];
   bit m_ovf  [2];
   bit m_conf;

   tl_traffic_model #(.QDEPTH(QDEPTH), .QW(QW), .PASS_CYCLES(PASS_CYCLES)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .La       (La),
      .Lb       (Lb),
      .arr_a    (arr_a),
      .arr_b    (arr_b),
      .Ta       (Ta),
      .Tb       (Tb),
      .cnt_a    (cnt_a),
      .cnt_b    (cnt_b),
      .pass_a   (pass_a),
      .pass_b   (pass_b),
      .ovf_a    (ovf_a),
      .ovf_b    (ovf_b),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   // m_age counts consecutive green cycles spent on the current car; it leaves on green cycle PASS_CYCLES+1.
   always @(posedge clk or negedge reset_n) begin : model
      int  c, a;
      bit  d, arrive;
      logic [1:0] lt;
      if (!reset_n) begin
         for (int s = 0; s < 2; s++) begin
            m_cnt[s]  <= 0;
            m_age[s]  <= 0;
            m_pass[s] <= 1'b0;
            m_ovf[s]  <= 1'b0;
         end
         m_conf <= 1'b0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            lt     = (s == 0) ? La : Lb;
            arrive = (s == 0) ? arr_a : arr_b;
            c = m_cnt[s];
            a = m_age[s];
            d = 1'b0;
            if (lt == GREEN) begin
               if (a > 0)
                  a = a + 1;
               else if (c > 0)
                  a = 1;
               if (a == PASS_CYCLES + 1) begin
                  d = 1'b1;
                  a = 0;
               end
            end else begin
               a = 0;
            end
            c = c + (arrive ? 1 : 0) - (d ? 1 : 0);
            if (c > QDEPTH) begin
               c = QDEPTH;
               m_ovf[s] <= 1'b1;
            end
            m_cnt[s]  <= c;
            m_age[s]  <= a;
            m_pass[s] <= d;
         end
         if ((La != RED && Lb != RED) || La == ILLEGAL || Lb == ILLEGAL)
            m_conf <= 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock cycle of stimulus; returns just after the edge that sampled it.
   task automatic applyStimulus(input logic [1:0] la, input logic [1:0] lb, input logic aa, input logic ab);
      @(negedge clk);
      La    = la;
      Lb    = lb;
      arr_a = aa;
      arr_b = ab;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      La      = RED;
      Lb      = RED;
      arr_a   = 1'b0;
      arr_b   = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic compareModel();
      logic [31:0] act, exp;
      act = '0;
      exp = '0;
      act[QW+2:0] = {Ta, pass_a, ovf_a, cnt_a};
      exp[QW+2:0] = {m_cnt[0] != 0, m_pass[0], m_ovf[0], m_cnt[0][QW-1:0]};
      checkOutput("model street A {T,pass,ovf,cnt}", act, exp);
      act[QW+2:0] = {Tb, pass_b, ovf_b, cnt_b};
      exp[QW+2:0] = {m_cnt[1] != 0, m_pass[1], m_ovf[1], m_cnt[1][QW-1:0]};
      checkOutput("model street B {T,pass,ovf,cnt}", act, exp);
      checkOutput("model conflict", {31'd0, conflict}, {31'd0, m_conf});
   endtask

   initial begin
      reset_n = 1'b0;
      La      = GREEN;
      Lb      = RED;
      arr_a   = 1'b1;
      arr_b   = 1'b0;

      fork
         forever begin
            @(negedge clk);
            compareModel();
         end
      join_none

      // Reset holds everything at zero despite green light and a pending arrival.
      #10;
      checkOutput("reset cnt_a", {28'd0, cnt_a}, 32'd0);
      checkOutput("reset outputs", {25'd0, Ta, Tb, pass_a, pass_b, ovf_a, ovf_b, conflict}, 32'd0);
      #2;
      reset_n = 1'b1;
      La      = RED;
      arr_a   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(RED, RED, 1'b0, 1'b0);
         checkOutput("idle after reset", {24'd0, Ta, pass_a, ovf_a, cnt_a, 1'b0}, 32'd0);
      end

      // Fill street A past its depth.
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(RED, RED, 1'b1, 1'b0);
         checkOutput("fill cnt_a", {28'd0, cnt_a}, (k < QDEPTH) ? k : QDEPTH);
         checkOutput("fill ovf_a", {31'd0, ovf_a}, (k > QDEPTH) ? 1 : 0);
      end
      checkOutput("fill Ta", {31'd0, Ta}, 32'd1);
      checkOutput("fill street B idle", {27'd0, Tb, cnt_b}, 32'd0);
      checkOutput("fill conflict", {31'd0, conflict}, 32'd0);

      // Drain three cars under steady green: departures on cycles 3, 6 and 9.
      doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(RED, RED, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(GREEN, RED, 1'b0, 1'b0);
         checkOutput("drain pass_a", {31'd0, pass_a}, (i % 3 == 0 && i <= 9) ? 1 : 0);
         checkOutput("drain cnt_a", {28'd0, cnt_a}, 3 - i / 3);
         checkOutput("drain Ta", {31'd0, Ta}, (i < 9) ? 1 : 0);
         checkOutput("drain pass_b", {31'd0, pass_b}, 32'd0);
      end

      // Yellow aborts a crossing on B; green restarts it from scratch.
      doReset();
      applyStimulus(RED, RED, 1'b0, 1'b1);
      applyStimulus(RED, RED, 1'b0, 1'b1);
      applyStimulus(RED, GREEN, 1'b0, 1'b0);
      checkOutput("abort enter pass_b", {31'd0, pass_b}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(RED, YELLOW, 1'b0, 1'b0);
         checkOutput("abort yellow {pass_b,cnt_b}", {27'd0, pass_b, cnt_b}, 32'd2);
      end
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(RED, GREEN, 1'b0, 1'b0);
         checkOutput("regreen pass_b", {31'd0, pass_b}, (i == 3) ? 1 : 0);
         checkOutput("regreen cnt_b", {28'd0, cnt_b}, (i == 3) ? 1 : 2);
      end

      // Arrival in the departure cycle on a full queue.
      doReset();
      for (int i = 0; i < QDEPTH; i++)
         applyStimulus(RED, RED, 1'b1, 1'b0);
      applyStimulus(GREEN, RED, 1'b0, 1'b0);
      applyStimulus(GREEN, RED, 1'b0, 1'b0);
      applyStimulus(GREEN, RED, 1'b1, 1'b0);
      checkOutput("simul pass_a", {31'd0, pass_a}, 32'd1);
      checkOutput("simul cnt_a", {28'd0, cnt_a}, QDEPTH);
      checkOutput("simul ovf_a", {31'd0, ovf_a}, 32'd0);

      // Conflict detection and stickiness.
      doReset();
      applyStimulus(GREEN, YELLOW, 1'b0, 1'b0);
      checkOutput("conflict green/yellow", {31'd0, conflict}, 32'd1);
      applyStimulus(RED, RED, 1'b0, 1'b0);
      applyStimulus(RED, RED, 1'b0, 1'b0);
      checkOutput("conflict sticky", {31'd0, conflict}, 32'd1);
      doReset();
      checkOutput("conflict cleared", {31'd0, conflict}, 32'd0);
      applyStimulus(RED, RED, 1'b1, 1'b0);
      applyStimulus(RED, RED, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(ILLEGAL, RED, 1'b0, 1'b0);
         checkOutput("illegal conflict", {31'd0, conflict}, 32'd1);
         checkOutput("illegal {pass_a,cnt_a}", {27'd0, pass_a, cnt_a}, 32'd2);
      end

      // Randomized traffic with occasional mid-run resets, checked by the model every cycle.
      doReset();
      begin
         logic [1:0] la, lb;
         int r;
         la = RED;
         lb = RED;
         for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699)
               doReset();
            if ($urandom_range(0, 5) == 0) begin
               r = $urandom_range(0, 15);
               if (r < 7) begin
                  la = 2'($urandom_range(0, 2));
                  lb = RED;
               end else if (r < 14) begin
                  la = RED;
                  lb = 2'($urandom_range(0, 2));
               end else begin
                  la = 2'($urandom_range(0, 3));
                  lb = 2'($urandom_range(0, 3));
               end
            end
            applyStimulus(la, lb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         end
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
